// File: rtl/frame_parser_v2.sv
// frame_parser_v2: UART command-frame parser.
// Frame layout: SOF1 SOF2 | CMD | LEN (1 or 2 bytes, MSB first) | PAYLOAD[LEN] | CHECKSUM.
// The checksum is a sum or XOR over CMD, LEN and PAYLOAD. A completed frame is held
// until frame_ack. The payload is read back through a registered read port.
module frame_parser_v2 #(
  parameter int MAX_PAYLOAD_LEN = 256,
  parameter int ADDR_WIDTH      = $clog2(MAX_PAYLOAD_LEN),
  parameter int LEN_BYTES       = 2,
  parameter int CSUM_MODE       = 0,
  parameter int TIMEOUT_CYCLES  = 100000,
  parameter logic [7:0] SOF1    = 8'hAA,
  parameter logic [7:0] SOF2    = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_valid,
  input  logic                  frame_ack,
  input  logic [ADDR_WIDTH-1:0] payload_read_addr,
  output logic [7:0]            payload_read_data,
  output logic                  parse_done,
  output logic                  parse_error,
  output logic [2:0]            error_code,
  output logic                  frame_valid,
  output logic                  busy,
  output logic [7:0]            cmd_out,
  output logic [15:0]           len_out
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SYNC     = 3'd1;
  localparam logic [2:0] S_CMD      = 3'd2;
  localparam logic [2:0] S_LEN_H    = 3'd3;
  localparam logic [2:0] S_LEN_L    = 3'd4;
  localparam logic [2:0] S_PAYLOAD  = 3'd5;
  localparam logic [2:0] S_CHECKSUM = 3'd6;
  localparam logic [2:0] S_HOLD     = 3'd7;

  localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD_LEN);
  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);
  localparam bit          TMO_EN  = (TIMEOUT_CYCLES != 0);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [2:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic [7:0]  rd_data_q;
  logic        mem_we;
  logic [15:0] len_new;
  logic        tmo_hit;

  logic [7:0]  mem [0:MAX_PAYLOAD_LEN-1];

  // Checksum accumulation step: sum mod 256 or XOR depending on CSUM_MODE.
  function automatic logic [7:0] csum_acc(input logic [7:0] acc, input logic [7:0] b);
    return (CSUM_MODE == 1) ? (acc ^ b) : (acc + b);
  endfunction

  assign busy    = (state_q != S_IDLE) && (state_q != S_HOLD);
  assign tmo_hit = TMO_EN && busy && (tmo_q == TMO_LIM);
  assign len_new = {len_q[15:8], uart_rx_data};

  // Next-state and datapath decode; a byte in the timeout cycle takes priority over the abort.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    valid_d = valid_q;
    mem_we  = 1'b0;
    tmo_d   = (uart_rx_valid || !busy) ? 32'd0 : tmo_q + 32'd1;

    if (state_q == S_HOLD && frame_ack) begin
      // Ack releases the frame; a simultaneous byte is treated as an IDLE byte.
      valid_d = 1'b0;
      state_d = (uart_rx_valid && uart_rx_data == SOF1) ? S_SYNC : S_IDLE;
    end else if (uart_rx_valid) begin
      case (state_q)
        S_IDLE: begin
          if (uart_rx_data == SOF1) state_d = S_SYNC;
        end
        S_SYNC: begin
          if (uart_rx_data == SOF2)      state_d = S_CMD;
          else if (uart_rx_data != SOF1) state_d = S_IDLE;
        end
        S_CMD: begin
          cmd_d   = uart_rx_data;
          csum_d  = uart_rx_data;
          len_d   = 16'd0;
          cnt_d   = 16'd0;
          state_d = (LEN_BYTES == 2) ? S_LEN_H : S_LEN_L;
        end
        S_LEN_H: begin
          len_d[15:8] = uart_rx_data;
          csum_d      = csum_acc(csum_q, uart_rx_data);
          state_d     = S_LEN_L;
        end
        S_LEN_L: begin
          len_d  = len_new;
          csum_d = csum_acc(csum_q, uart_rx_data);
          if ({1'b0, len_new} > MAX_LEN) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 3'd1;
          end else if (len_new == 16'd0) begin
            state_d = S_CHECKSUM;
          end else begin
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 16'd1;
          csum_d = csum_acc(csum_q, uart_rx_data);
          if (cnt_q == len_q - 16'd1) state_d = S_CHECKSUM;
        end
        S_CHECKSUM: begin
          if (uart_rx_data == csum_q) begin
            state_d = S_HOLD;
            done_d  = 1'b1;
            valid_d = 1'b1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 3'd2;
          end
        end
        S_HOLD: begin
          // Overrun: the held frame is kept and the byte is dropped.
          err_d  = 1'b1;
          code_d = 3'd4;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = 3'd3;
    end
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'd0;
      len_q   <= 16'd0;
      cnt_q   <= 16'd0;
      csum_q  <= 8'd0;
      tmo_q   <= 32'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  // Payload buffer write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cnt_q[ADDR_WIDTH-1:0]] <= uart_rx_data;
  end

  // Registered payload read port.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 8'd0;
    else     rd_data_q <= mem[payload_read_addr];
  end

  assign payload_read_data = rd_data_q;
  assign parse_done        = done_q;
  assign parse_error       = err_q;
  assign error_code        = code_q;
  assign frame_valid       = valid_q;
  assign cmd_out           = cmd_q;
  assign len_out           = len_q;

endmodule

// File: tb/tb_frame_parser_v2.sv
// Directed bench for frame_parser_v2: a vector table for the sum-mode parser plus
// hand-written sequences for the read port, XOR mode and the inter-byte timeout.
module tb_frame_parser_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        ack = 1'b0;
  logic [7:0]  rd_addr = 8'h00;

  logic [7:0]  d0_rd, d1_rd;
  logic        d0_done, d1_done, d0_err, d1_err, d0_fv, d1_fv, d0_busy, d1_busy;
  logic [2:0]  d0_code, d1_code;
  logic [7:0]  d0_cmd, d1_cmd;
  logic [15:0] d0_len, d1_len;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  frame_parser_v2 #(.CSUM_MODE(0), .TIMEOUT_CYCLES(16)) dut0 (
    .clk(clk), .rst(rst), .uart_rx_data(rx_data), .uart_rx_valid(rx_valid),
    .frame_ack(ack), .payload_read_addr(rd_addr), .payload_read_data(d0_rd),
    .parse_done(d0_done), .parse_error(d0_err), .error_code(d0_code),
    .frame_valid(d0_fv), .busy(d0_busy), .cmd_out(d0_cmd), .len_out(d0_len));

  frame_parser_v2 #(.CSUM_MODE(1), .TIMEOUT_CYCLES(16)) dut1 (
    .clk(clk), .rst(rst), .uart_rx_data(rx_data), .uart_rx_valid(rx_valid),
    .frame_ack(ack), .payload_read_addr(rd_addr), .payload_read_data(d1_rd),
    .parse_done(d1_done), .parse_error(d1_err), .error_code(d1_code),
    .frame_valid(d1_fv), .busy(d1_busy), .cmd_out(d1_cmd), .len_out(d1_len));

  typedef struct {
    logic        r, v, a;
    logic [7:0]  d;
    logic        done, err;
    logic [2:0]  code;
    logic        fv, busy;
    logic [7:0]  cmd;
    logic [15:0] len;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, v, a, input logic [7:0] d,
                              input logic done, err, input logic [2:0] code,
                              input logic fv, busy, input logic [7:0] cmd,
                              input logic [15:0] len);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.d = d; t.done = done; t.err = err; t.code = code;
    t.fv = fv; t.busy = busy; t.cmd = cmd; t.len = len;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply inputs for one clock and sample outputs 1 time unit after the edge.
  task automatic drive(input logic r, v, a, input logic [7:0] d);
    rst = r; rx_valid = v; ack = a; rx_data = d;
    @(posedge clk);
    #1;
    rst = 1'b0; rx_valid = 1'b0; ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    drive(1'b0, 1'b1, 1'b0, d);
  endtask

  logic [7:0] frm_ok [8];

  initial begin
    // rst v ack data | done err code fv busy cmd len
    tbl.push_back(mk(1,0,0,8'h00, 0,0,3'd0,0,0,8'h00,16'h0000)); // 0 reset
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd0,0,1,8'h00,16'h0000)); // SOF1
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd0,0,1,8'h00,16'h0000)); // SOF2
    tbl.push_back(mk(0,1,0,8'h01, 0,0,3'd0,0,1,8'h01,16'h0000)); // CMD
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd0,0,1,8'h01,16'h0000)); // LEN_H
    tbl.push_back(mk(0,1,0,8'h02, 0,0,3'd0,0,1,8'h01,16'h0002)); // LEN_L
    tbl.push_back(mk(0,1,0,8'h10, 0,0,3'd0,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h20, 0,0,3'd0,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h33, 1,0,3'd0,1,0,8'h01,16'h0002)); // checksum ok
    tbl.push_back(mk(0,0,0,8'h00, 0,0,3'd0,1,0,8'h01,16'h0002)); // done is one cycle
    tbl.push_back(mk(0,1,0,8'hAA, 0,1,3'd4,1,0,8'h01,16'h0002)); // overrun in HOLD
    tbl.push_back(mk(0,0,0,8'h00, 0,0,3'd4,1,0,8'h01,16'h0002));
    tbl.push_back(mk(0,1,1,8'hAA, 0,0,3'd4,0,1,8'h01,16'h0002)); // ack + SOF1 -> SYNC
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd4,0,1,8'h01,16'h0002)); // -> CMD
    tbl.push_back(mk(0,1,0,8'h07, 0,0,3'd4,0,1,8'h07,16'h0000)); // captured as CMD
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd4,0,1,8'h07,16'h0000));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd4,0,1,8'h07,16'h0000)); // len 0 -> CHECKSUM
    tbl.push_back(mk(0,1,0,8'h07, 1,0,3'd4,1,0,8'h07,16'h0000)); // zero-length frame
    tbl.push_back(mk(0,0,1,8'h00, 0,0,3'd4,0,0,8'h07,16'h0000)); // ack alone
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd4,0,1,8'h07,16'h0000));
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd4,0,1,8'h07,16'h0000));
    tbl.push_back(mk(0,1,0,8'h03, 0,0,3'd4,0,1,8'h03,16'h0000));
    tbl.push_back(mk(0,1,0,8'h01, 0,0,3'd4,0,1,8'h03,16'h0100));
    tbl.push_back(mk(0,1,0,8'h01, 0,1,3'd1,0,0,8'h03,16'h0101)); // 257 > 256
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd1,0,1,8'h03,16'h0101)); // new SOF1
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd1,0,1,8'h03,16'h0101)); // resync
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd1,0,1,8'h03,16'h0101));
    tbl.push_back(mk(0,1,0,8'h02, 0,0,3'd1,0,1,8'h02,16'h0000));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd1,0,1,8'h02,16'h0000));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd1,0,1,8'h02,16'h0000));
    tbl.push_back(mk(0,1,0,8'h02, 1,0,3'd1,1,0,8'h02,16'h0000));
    tbl.push_back(mk(0,0,1,8'h00, 0,0,3'd1,0,0,8'h02,16'h0000));
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd1,0,1,8'h02,16'h0000)); // sum-mode bad csum
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd1,0,1,8'h02,16'h0000));
    tbl.push_back(mk(0,1,0,8'h01, 0,0,3'd1,0,1,8'h01,16'h0000));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd1,0,1,8'h01,16'h0000));
    tbl.push_back(mk(0,1,0,8'h02, 0,0,3'd1,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'hF0, 0,0,3'd1,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'hF0, 0,0,3'd1,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h03, 0,1,3'd2,0,0,8'h01,16'h0002)); // sum is E3
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd2,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd2,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,1,8'h01, 0,0,3'd2,0,1,8'h01,16'h0000)); // ack outside HOLD
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd2,0,1,8'h01,16'h0000));
    tbl.push_back(mk(0,1,0,8'h02, 0,0,3'd2,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h10, 0,0,3'd2,0,1,8'h01,16'h0002)); // mid-payload
    tbl.push_back(mk(1,0,0,8'h00, 0,0,3'd0,0,0,8'h00,16'h0000)); // reset mid-frame
    tbl.push_back(mk(0,1,0,8'hAA, 0,0,3'd0,0,1,8'h00,16'h0000));
    tbl.push_back(mk(0,1,0,8'h55, 0,0,3'd0,0,1,8'h00,16'h0000));
    tbl.push_back(mk(0,1,0,8'h01, 0,0,3'd0,0,1,8'h01,16'h0000));
    tbl.push_back(mk(0,1,0,8'h00, 0,0,3'd0,0,1,8'h01,16'h0000));
    tbl.push_back(mk(0,1,0,8'h02, 0,0,3'd0,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h10, 0,0,3'd0,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h20, 0,0,3'd0,0,1,8'h01,16'h0002));
    tbl.push_back(mk(0,1,0,8'h33, 1,0,3'd0,1,0,8'h01,16'h0002));

    frm_ok = '{8'hAA, 8'h55, 8'h01, 8'h00, 8'h02, 8'hF0, 8'hF0, 8'h03};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d", i),
          {1'b0, d0_done, d0_err, d0_code, d0_fv, d0_busy, d0_cmd, d0_len},
          {1'b0, tbl[i].done, tbl[i].err, tbl[i].code, tbl[i].fv, tbl[i].busy,
           tbl[i].cmd, tbl[i].len});
    end

    // Registered read port on the held frame (payload 10 20).
    rd_addr = 8'd1;
    drive(0, 0, 0, 8'h00);
    chk("rd_addr1", 32'(d0_rd), 32'h20);
    rd_addr = 8'd0;
    #1;
    chk("rd_latency", 32'(d0_rd), 32'h20);
    drive(0, 0, 0, 8'h00);
    chk("rd_addr0", 32'(d0_rd), 32'h10);

    // Reset clears the read register and releases the frame.
    drive(1, 0, 0, 8'h00);
    chk("rst_rd", 32'(d0_rd), 32'h00);
    chk("rst_fv", 32'(d0_fv), 32'h0);

    // Checksum mode: final byte 03 is the XOR, E3 is the sum.
    for (int k = 0; k < 8; k++) send(frm_ok[k]);
    chk("xor_03_done", {d1_done, d1_err, d1_fv}, 3'b101);
    chk("sum_03_err", {d0_done, d0_err, 1'b0, d0_code}, {2'b01, 1'b0, 3'd2});
    drive(1, 0, 0, 8'h00);
    for (int k = 0; k < 7; k++) send(frm_ok[k]);
    send(8'hE3);
    chk("sum_E3_done", {d0_done, d0_err, d0_fv}, 3'b101);
    chk("xor_E3_err", {d1_done, d1_err, 1'b0, d1_code}, {2'b01, 1'b0, 3'd2});
    drive(1, 0, 0, 8'h00);

    // Inter-byte timeout after AA 55 05.
    send(8'hAA); send(8'h55); send(8'h05);
    chk("tmo_busy", 32'(d0_busy), 32'h1);
    begin
      int  n;
      bit  seen;
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
        drive(0, 0, 0, 8'h00);
        n++;
        if (d0_err) seen = 1'b1;
      end
      chk("tmo_seen", 32'(seen), 32'h1);
      chk("tmo_delay", 32'(n >= 16 && n <= 18), 32'h1);
      chk("tmo_code", 32'(d0_code), 32'd3);
      chk("tmo_busy_low", 32'(d0_busy), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_parser_v2.md
Name: frame_parser_v2

Overview:
- Next-generation UART command-frame parser: SOF1 SOF2 | CMD | LEN (1 or 2 bytes, MSB first) | PAYLOAD[LEN] | CHECKSUM.
- Adds selectable checksum mode, inter-byte timeout, SOF resync and coded errors over the previous parser.
- Holds each completed frame until a downstream command dispatcher acknowledges it.
- Sits between the UART RX byte stream and the command dispatcher; the dispatcher reads the payload through a registered read port.

Parameters:
- MAX_PAYLOAD_LEN, 256: payload buffer depth and maximum legal LEN.
- ADDR_WIDTH, $clog2(MAX_PAYLOAD_LEN): payload read address width.
- LEN_BYTES, 2: length field size; legal values 1 or 2.
- CSUM_MODE, 0: 0 = 8-bit sum mod 256; 1 = 8-bit XOR.
- TIMEOUT_CYCLES, 100000: idle cycles allowed between bytes inside a frame; 0 disables the timeout.
- SOF1, 8'hAA: first sync byte.
- SOF2, 8'h55: second sync byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- uart_rx_data  in  8  received byte.
- uart_rx_valid  in  1  one-cycle strobe; uart_rx_data is valid this cycle.
- frame_ack  in  1  dispatcher releases the held frame.
- payload_read_addr  in  ADDR_WIDTH  payload read address.
- payload_read_data  out  8  payload byte, registered.
- parse_done  out  1  one-cycle pulse when a good frame is complete.
- parse_error  out  1  one-cycle pulse when an error is detected.
- error_code  out  3  cause of the last error; held until the next error.
- frame_valid  out  1  high while a good frame is held.
- busy  out  1  high in any state other than IDLE or HOLD.
- cmd_out  out  8  command byte of the held frame.
- len_out  out  16  length of the held frame.

Behaviour:
- Reset: one cycle of rst=1 forces state IDLE and drives every output, counter and checksum to 0. Reset has this effect mid-frame too; the partial frame is discarded with no error pulse. Payload memory is not cleared.
- Clock and reset are the single clock clk and a synchronous active-high rst; no other clock or reset exists.
- States: IDLE, SYNC, CMD, LEN_H, LEN_L, PAYLOAD, CHECKSUM, HOLD. All transitions are registered, and every state except HOLD advances only on uart_rx_valid. No transient state exists.
- IDLE: a byte equal to SOF1 moves to SYNC; any other byte is ignored.
- SYNC: SOF2 moves to CMD. SOF1 stays in SYNC (resync on a repeated SOF1). Any other byte returns to IDLE.
- CMD: captures the byte into cmd_out and loads the checksum with it.
- LEN_H: writes len_out[15:8] and accumulates the byte into the checksum. When LEN_BYTES=1 this state is skipped and len_out[15:8] is 0.
- LEN_L: writes len_out[7:0] and accumulates the byte. The length is evaluated combinationally from the incoming byte:
  - len > MAX_PAYLOAD_LEN: go to IDLE, pulse parse_error, error_code=1.
  - len == 0: go to CHECKSUM.
  - otherwise: go to PAYLOAD.
- PAYLOAD: writes mem[cnt], increments cnt and accumulates the byte. The byte with cnt == len_out-1 moves to CHECKSUM.
- CHECKSUM: a received byte equal to the accumulator moves to HOLD, pulses parse_done and sets frame_valid. A mismatch goes to IDLE, pulses parse_error, error_code=2.
- Checksum covers CMD, the LEN bytes and the PAYLOAD bytes; SOF bytes are excluded. Accumulation is sum mod 256 or XOR, selected by CSUM_MODE.
- Every pulse is asserted the cycle after the byte that caused it.
- HOLD: cmd_out, len_out and payload memory stay frozen.
  - frame_ack: clears frame_valid and goes to IDLE.
  - uart_rx_valid without frame_ack: the byte is dropped, parse_error pulses, error_code=4 (overrun), state stays HOLD.
  - frame_ack and uart_rx_valid in the same cycle: the ack takes effect and the byte is treated as an IDLE byte, so SOF1 goes directly to SYNC.
  - frame_ack outside HOLD is ignored.
- Timeout: the counter clears on every uart_rx_valid and on entry to SYNC, and counts only in SYNC through CHECKSUM. When it reaches TIMEOUT_CYCLES with no byte in that cycle, the frame aborts to IDLE with parse_error and error_code=3. A byte arriving in that same cycle wins over the timeout.
- Read port: payload_read_data = mem[payload_read_addr] registered, so data appears one cycle after the address. The port is usable in any state, but its contents are guaranteed only while frame_valid is high.
- cmd_out and len_out may change during a new frame after the ack; the dispatcher samples them only while frame_valid is high.

Test Plan:
- CSUM_MODE=0, bytes AA 55 01 00 02 10 20 33: parse_done pulses one cycle after 33; frame_valid=1, cmd_out=01, len_out=0002. Reading addr 0 then 1 returns 10 then 20, each one cycle after its address.
- CSUM_MODE=1, frame AA 55 01 00 02 F0 F0 03 -> parse_done. The same frame with a final byte of E3 -> parse_error, error_code=2. Repeat with CSUM_MODE=0: final E3 is accepted and final 03 is rejected.
- Length field 01 01 with MAX_PAYLOAD_LEN=256 -> parse_error with error_code=1 the cycle after the LEN_L byte; the next byte, AA, is accepted as a new SOF1. Zero-length frame AA 55 07 00 00 07 -> parse_done, len_out=0.
- Stream AA AA 55 02 00 00 02 -> frame accepted (resync). With TIMEOUT_CYCLES=16, send AA 55 05 then no byte for 16 cycles -> parse_error with error_code=3, busy falls.
- While held (no ack) send AA -> parse_error with error_code=4, frame_valid stays 1, cmd_out unchanged. Then frame_ack together with AA, followed by 55 -> state is CMD.
- Assert rst mid-PAYLOAD -> next cycle all outputs are 0 and state is IDLE; a following complete frame parses correctly.
